// File: rtl/decoder_pkg.sv
// Shared defaults, data types and output-stage states for the one-hot decoder.
package decoder_pkg;

    localparam int DEFAULT_INPUT_LENGTH  = 4;
    localparam int DEFAULT_OUTPUT_LENGTH = 1 << DEFAULT_INPUT_LENGTH;
    localparam int DEFAULT_FIFO_DEPTH    = 2;
    localparam int DEFAULT_COUNT_WIDTH   = 8;

    typedef logic [DEFAULT_INPUT_LENGTH-1:0]  code_t;
    typedef logic [DEFAULT_OUTPUT_LENGTH-1:0] onehot_t;

    typedef enum logic {EMPTY, FULL} stage_state_t;

endpackage

// File: rtl/decoder_fifo.sv
// Synchronous code FIFO; pushes while full and pops while empty are ignored.
module decoder_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/decoder_with_handshake.sv
// Buffered 4-to-16 one-hot decoder with valid/ready on both sides and a handshake counter.
module decoder_with_handshake
    import decoder_pkg::*;
#(
    parameter int INPUT_LENGTH  = DEFAULT_INPUT_LENGTH,
    parameter int OUTPUT_LENGTH = DEFAULT_OUTPUT_LENGTH,
    parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
    parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INPUT_LENGTH-1:0]  input_wire,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUTPUT_LENGTH-1:0] output_wire,
    output logic [COUNT_WIDTH-1:0]   decode_count
);

    stage_state_t            state;
    stage_state_t            next_state;
    logic [INPUT_LENGTH-1:0] head_code;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    load;
    logic                    handshake;

    function automatic logic [OUTPUT_LENGTH-1:0] decode(input logic [INPUT_LENGTH-1:0] code);
        return OUTPUT_LENGTH'(1) << code;
    endfunction

    // in_ready depends only on occupancy, never on out_ready.
    assign in_ready  = !reset && !fifo_full;
    assign out_valid = (state == FULL);
    assign handshake = out_valid && out_ready;
    assign load      = enable && !fifo_empty && (!out_valid || out_ready);

    decoder_fifo #(
        .WIDTH (INPUT_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid && in_ready),
        .push_data (input_wire),
        .pop       (load),
        .pop_data  (head_code),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            EMPTY:   if (load) next_state = FULL;
            FULL:    if (handshake && !load) next_state = EMPTY;
            default: next_state = EMPTY;
        endcase
    end

    // The word register is cleared on drain so it reads zero whenever out_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            output_wire <= '0;
        end else if (load) begin
            output_wire <= decode(head_code);
        end else if (handshake) begin
            output_wire <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            decode_count <= '0;
        end else if (handshake) begin
            decode_count <= decode_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_decoder_with_handshake.sv
// Randomized and directed bench for decoder_with_handshake against a queue-based reference model.
module tb_decoder_with_handshake;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  input_wire;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] output_wire;
    logic [7:0]  decode_count;

    int          check_count = 0;
    int          error_count = 0;

    int          model_q[$];
    bit          model_valid;
    logic [15:0] model_word;
    int          model_count;

    decoder_with_handshake dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .input_wire   (input_wire),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .output_wire  (output_wire),
        .decode_count (decode_count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs to the model with the current inputs, then advance both by one edge.
    task automatic tick();
        bit exp_ready;
        bit hs;
        bit ld;
        bit psh;
        #1;
        exp_ready = !reset && (model_q.size() < DEPTH);
        check_output("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        check_output("out_valid", {31'd0, out_valid}, {31'd0, model_valid});
        check_output("output_wire", {16'd0, output_wire}, {16'd0, model_word});
        check_output("decode_count", {24'd0, decode_count}, model_count);
        if (reset) begin
            model_q.delete();
            model_valid = 0;
            model_word  = '0;
            model_count = 0;
        end else begin
            hs  = model_valid && out_ready;
            ld  = enable && (model_q.size() > 0) && (!model_valid || out_ready);
            psh = in_valid && exp_ready;
            if (hs) model_count = (model_count + 1) % 256;
            if (ld) begin
                model_word  = 16'(1) << model_q.pop_front();
                model_valid = 1;
            end else if (hs) begin
                model_valid = 0;
                model_word  = '0;
            end
            if (psh) model_q.push_back(int'(input_wire));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit rst, input bit en, input bit iv,
                                  input logic [3:0] code, input bit ordy);
        reset      = rst;
        enable     = en;
        in_valid   = iv;
        input_wire = code;
        out_ready  = ordy;
        tick();
    endtask

    // Hold a code on the input until it is accepted, bounded by a cycle budget.
    task automatic push_code(input logic [3:0] code, input bit en, input bit ordy);
        bit accepted = 0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            reset = 0; enable = en; in_valid = 1; input_wire = code; out_ready = ordy;
            #1;
            accepted = in_ready;
            tick();
        end
        if (!accepted) check_output("push_timeout", 32'd0, 32'd1);
        in_valid = 0;
    endtask

    task automatic idle(input int n, input bit en, input bit ordy);
        for (int i = 0; i < n; i++) apply_stimulus(0, en, 0, 4'h0, ordy);
    endtask

    initial begin
        reset = 1; enable = 0; in_valid = 0; input_wire = '0; out_ready = 0;
        model_valid = 0; model_word = '0; model_count = 0;

        apply_stimulus(1, 0, 0, 4'h0, 0);
        apply_stimulus(1, 0, 0, 4'h0, 0);

        // Single code 3: visible one edge after acceptance
        apply_stimulus(0, 1, 1, 4'h3, 1);
        apply_stimulus(0, 1, 0, 4'h0, 1);
        check_output("first_word", {16'd0, output_wire}, 32'h0008);
        check_output("first_valid", {31'd0, out_valid}, 32'd1);
        apply_stimulus(0, 1, 0, 4'h0, 1);
        check_output("first_count", {24'd0, decode_count}, 32'd1);

        // Back-to-back stream of all codes
        for (int c = 0; c < 16; c++) apply_stimulus(0, 1, 1, 4'(c), 1);
        idle(4, 1, 1);
        check_output("stream_count", {24'd0, decode_count}, 32'd17);

        // Backpressure: output holds 0002, FIFO fills with 2 and 3
        push_code(4'h1, 1, 0);
        push_code(4'h2, 1, 0);
        push_code(4'h3, 1, 0);
        idle(2, 1, 0);
        check_output("bp_hold", {16'd0, output_wire}, 32'h0002);
        check_output("bp_full", {31'd0, in_ready}, 32'd0);
        apply_stimulus(0, 1, 1, 4'h4, 0);
        idle(5, 1, 1);

        // enable low: FIFO fills, nothing loads
        push_code(4'h5, 0, 1);
        push_code(4'h6, 0, 1);
        idle(2, 0, 1);
        check_output("en0_valid", {31'd0, out_valid}, 32'd0);
        check_output("en0_ready", {31'd0, in_ready}, 32'd0);
        apply_stimulus(0, 1, 0, 4'h0, 1);
        check_output("en1_word5", {16'd0, output_wire}, 32'h0020);
        apply_stimulus(0, 1, 0, 4'h0, 1);
        check_output("en1_word6", {16'd0, output_wire}, 32'h0040);
        idle(2, 1, 1);

        // Reset while full and valid
        push_code(4'h7, 1, 0);
        push_code(4'h8, 1, 0);
        push_code(4'h9, 1, 0);
        apply_stimulus(1, 1, 0, 4'h0, 0);
        check_output("rst_valid", {31'd0, out_valid}, 32'd0);
        check_output("rst_word", {16'd0, output_wire}, 32'd0);
        check_output("rst_count", {24'd0, decode_count}, 32'd0);
        reset = 0;
        #1;
        check_output("rst_ready", {31'd0, in_ready}, 32'd1);

        // 256 handshakes wrap the counter
        for (int i = 0; i < 256; i++) apply_stimulus(0, 1, 1, 4'($urandom_range(0, 15)), 1);
        idle(4, 1, 1);
        check_output("wrap_count", {24'd0, decode_count}, 32'd0);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                           $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                           ($urandom_range(0, 2) != 0));
        end
        idle(6, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
